control_escrituras_mem_externa: RTL and testbench

Write-side counterpart of the external-memory read controller. It drains filtered pixel words from the output buffer (buffer_resultados) and issues single-word write requests to external memory. It starts at a base address and steps one 32-bit word per write until the programmed number of writes is done, then pulses completion. It sits between the filter-output buffer and the external memory port.

---
 rtl/control_escrituras_mem_externa_pkg.sv | 16 +
 rtl/registro_sumador_dinamico_async.sv | 28 ++
 rtl/control_escrituras_mem_externa.sv | 115 +++++++++++
 tb/tb_control_escrituras_mem_externa.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/control_escrituras_mem_externa_pkg.sv
// Shared types and defaults for the external-memory write controller.
package control_escrituras_mem_externa_pkg;

  typedef enum logic [2:0] {
    E_INICIO           = 3'd0,
    E_ESPERA_DATO      = 3'd1,
    E_LEER_BUFFER      = 3'd2,
    E_CAPTURA          = 3'd3,
    E_ESCRITURA        = 3'd4,
    E_ESPERA_ESCRITURA = 3'd5,
    E_FIN              = 3'd6
  } estado_t;

  localparam int unsigned INCREMENTO_DIRECCION_DEF = 4;

endpackage

// File: rtl/registro_sumador_dinamico_async.sv
// Loadable accumulator register: loads a base value, or adds a fixed step on request.
module registro_sumador_dinamico_async #(
  parameter int unsigned BITS          = 24,
  parameter int unsigned CANTIDAD_SUMA = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            i_cargar,
  input  logic [BITS-1:0] i_valor_carga,
  input  logic            i_sumar,
  output logic [BITS-1:0] o_valor
);

  logic [BITS-1:0] r_valor;

  // Load has priority over add; the sum wraps silently at the register width.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      r_valor <= '0;
    else if (i_cargar)
      r_valor <= i_valor_carga;
    else if (i_sumar)
      r_valor <= r_valor + BITS'(CANTIDAD_SUMA);
  end

  assign o_valor = r_valor;

endmodule

// File: rtl/control_escrituras_mem_externa.sv
// Drains the result buffer into external memory, one word per write request.
module control_escrituras_mem_externa
  import control_escrituras_mem_externa_pkg::*;
#(
  parameter int unsigned BITS_DIRECCION_MEM   = 24,
  parameter int unsigned BITS_DATOS_MEM       = 32,
  parameter int unsigned INCREMENTO_DIRECCION = INCREMENTO_DIRECCION_DEF
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          iniciar,
  input  logic [BITS_DIRECCION_MEM-1:0] direccion_mem_destino_img,
  input  logic [BITS_DIRECCION_MEM-1:0] escrituras_totales_mem,
  input  logic                          buf_data_available,
  input  logic [BITS_DATOS_MEM-1:0]     buf_data,
  input  logic                          escritura_mem_completada,
  output logic                          read_buf,
  output logic                          write_mem,
  output logic [BITS_DIRECCION_MEM-1:0] address_mem,
  output logic [BITS_DATOS_MEM-1:0]     write_data_mem,
  output logic                          proceso_terminado
);

  estado_t                       r_estado, w_estado_sig;
  logic [BITS_DIRECCION_MEM-1:0] r_total;
  logic [BITS_DATOS_MEM-1:0]     r_datos;
  logic [BITS_DIRECCION_MEM-1:0] w_contador;
  logic                          w_cargar;
  logic                          w_ack;

  assign w_cargar = (r_estado == E_INICIO) && iniciar;
  // An ack counts only while a write is actually outstanding.
  assign w_ack    = ((r_estado == E_ESCRITURA) || (r_estado == E_ESPERA_ESCRITURA))
                    && escritura_mem_completada;

  registro_sumador_dinamico_async #(
    .BITS          (BITS_DIRECCION_MEM),
    .CANTIDAD_SUMA (INCREMENTO_DIRECCION)
  ) u_direccion (
    .clk           (clk),
    .reset         (reset),
    .i_cargar      (w_cargar),
    .i_valor_carga (direccion_mem_destino_img),
    .i_sumar       (w_ack),
    .o_valor       (address_mem)
  );

  registro_sumador_dinamico_async #(
    .BITS          (BITS_DIRECCION_MEM),
    .CANTIDAD_SUMA (1)
  ) u_contador (
    .clk           (clk),
    .reset         (reset),
    .i_cargar      (w_cargar),
    .i_valor_carga ('0),
    .i_sumar       (w_ack),
    .o_valor       (w_contador)
  );

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_estado <= E_INICIO;
    else       r_estado <= w_estado_sig;
  end

  // Latch the requested write count at start.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)         r_total <= '0;
    else if (w_cargar) r_total <= escrituras_totales_mem;
  end

  // Capture buffer data exactly one cycle after the pop; held until the next capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                       r_datos <= '0;
    else if (r_estado == E_CAPTURA)  r_datos <= buf_data;
  end

  assign write_data_mem = r_datos;

  // Next-state and Moore output decode.
  always_comb begin
    w_estado_sig      = r_estado;
    read_buf          = 1'b0;
    write_mem         = 1'b0;
    proceso_terminado = 1'b0;
    case (r_estado)
      E_INICIO: begin
        if (iniciar)
          w_estado_sig = (escrituras_totales_mem == '0) ? E_FIN : E_ESPERA_DATO;
      end
      E_ESPERA_DATO: begin
        if (w_contador == r_total)   w_estado_sig = E_FIN;
        else if (buf_data_available) w_estado_sig = E_LEER_BUFFER;
      end
      E_LEER_BUFFER: begin
        read_buf     = 1'b1;
        w_estado_sig = E_CAPTURA;
      end
      E_CAPTURA: w_estado_sig = E_ESCRITURA;
      E_ESCRITURA: begin
        write_mem    = 1'b1;
        w_estado_sig = w_ack ? E_ESPERA_DATO : E_ESPERA_ESCRITURA;
      end
      E_ESPERA_ESCRITURA: begin
        if (w_ack) w_estado_sig = E_ESPERA_DATO;
      end
      E_FIN: begin
        proceso_terminado = 1'b1;
        w_estado_sig      = E_INICIO;
      end
      default: w_estado_sig = E_INICIO;
    endcase
  end

endmodule

// File: tb/tb_control_escrituras_mem_externa.sv
// Directed bench for the external-memory write controller.
module tb_control_escrituras_mem_externa;

  logic        clk = 1'b0;
  logic        reset;
  logic        iniciar;
  logic [23:0] direccion_mem_destino_img;
  logic [23:0] escrituras_totales_mem;
  logic        buf_data_available;
  logic [31:0] buf_data;
  logic        escritura_mem_completada;
  logic        read_buf;
  logic        write_mem;
  logic [23:0] address_mem;
  logic [31:0] write_data_mem;
  logic        proceso_terminado;

  always #5 clk = ~clk;

  control_escrituras_mem_externa #(
    .BITS_DIRECCION_MEM   (24),
    .BITS_DATOS_MEM       (32),
    .INCREMENTO_DIRECCION (4)
  ) dut (
    .clk                       (clk),
    .reset                     (reset),
    .iniciar                   (iniciar),
    .direccion_mem_destino_img (direccion_mem_destino_img),
    .escrituras_totales_mem    (escrituras_totales_mem),
    .buf_data_available        (buf_data_available),
    .buf_data                  (buf_data),
    .escritura_mem_completada  (escritura_mem_completada),
    .read_buf                  (read_buf),
    .write_mem                 (write_mem),
    .address_mem               (address_mem),
    .write_data_mem            (write_data_mem),
    .proceso_terminado         (proceso_terminado)
  );

  typedef struct {
    logic [23:0] base;
    logic [23:0] total;
    int          ack_dly;
    int          gap;
    logic [23:0] exp_last;
    logic [23:0] exp_final;
    int          exp_rd;
    int          exp_wr;
    int          exp_wgap;
    int          exp_fin;
  } vec_t;

  vec_t vecs[5];
  vec_t vh;

  int n_cmp = 0;
  int n_bad = 0;

  int          cyc;
  int          avail_cyc;
  int          ack_dly;
  int          ack_cnt;
  logic        hold;
  logic [31:0] wbase;
  int          n_rd, n_wr, n_fin;
  int          first_rd, fin_cyc;
  int          wr_cyc[8];
  logic [23:0] wr_addr[8];
  logic [31:0] wr_data[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One clock: observe DUT at the falling edge and update the buffer/memory models.
  task automatic step();
    @(negedge clk);
    cyc++;
    escritura_mem_completada = 1'b0;
    if (read_buf) begin
      buf_data = wbase + 32'(n_rd);
      if (n_rd == 0) first_rd = cyc;
      n_rd++;
      hold = 1'b1;
    end else if (hold) begin
      hold = 1'b0;
    end else begin
      buf_data = 32'hDEAD_0000 + 32'(cyc);
    end
    if (write_mem) begin
      if (n_wr < 8) begin
        wr_cyc[n_wr]  = cyc;
        wr_addr[n_wr] = address_mem;
        wr_data[n_wr] = write_data_mem;
      end
      n_wr++;
      if (ack_dly == 0) escritura_mem_completada = 1'b1;
      else              ack_cnt = ack_dly;
    end else if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) escritura_mem_completada = 1'b1;
    end
    if (proceso_terminado) begin
      n_fin++;
      fin_cyc = cyc;
    end
    buf_data_available = (cyc >= avail_cyc);
  endtask

  task automatic start(input logic [23:0] base, input logic [23:0] total,
                       input int dly, input int gap, input logic [31:0] wb, output int s);
    n_rd = 0; n_wr = 0; n_fin = 0; first_rd = -1; fin_cyc = -1;
    ack_cnt = 0; ack_dly = dly; wbase = wb;
    step();
    s = cyc;
    avail_cyc = s + 1 + gap;
    direccion_mem_destino_img = base;
    escrituras_totales_mem    = total;
    iniciar = 1'b1;
    step();
    iniciar = 1'b0;
  endtask

  // Runs one job until proceso_terminado and checks it against the vector.
  task automatic run_case(input vec_t v, input logic [31:0] wb);
    int s;
    logic [23:0] ea;
    start(v.base, v.total, v.ack_dly, v.gap, wb, s);
    for (int k = 0; k < 300 && n_fin == 0; k++) step();
    chk("fin_seen", 32'(n_fin), 32'd1);
    chk("fin_cycle", 32'(fin_cyc - s), 32'(v.exp_fin));
    chk("fin_addr", {8'h0, address_mem}, {8'h0, v.exp_final});
    chk("rd_count", 32'(n_rd), 32'(v.total));
    chk("wr_count", 32'(n_wr), 32'(v.total));
    if (v.total != 0) begin
      chk("first_rd", 32'(first_rd - s), 32'(v.exp_rd));
      chk("first_wr", 32'(wr_cyc[0] - s), 32'(v.exp_wr));
      chk("last_addr", {8'h0, wr_addr[v.total-1]}, {8'h0, v.exp_last});
      for (int i = 0; i < int'(v.total) && i < 8; i++) begin
        ea = v.base + 24'(4 * i);
        chk("wr_addr", {8'h0, wr_addr[i]}, {8'h0, ea});
        chk("wr_data", wr_data[i], wb + 32'(i));
      end
    end
    if (v.total > 1) chk("wr_spacing", 32'(wr_cyc[1] - wr_cyc[0]), 32'(v.exp_wgap));
  endtask

  initial begin
    vecs[0] = '{24'h000100, 24'd3, 2, 0,  24'h000108, 24'h00010C, 2,  4,  6, 20};
    vecs[1] = '{24'h000040, 24'd0, 0, 0,  24'h000000, 24'h000040, 0,  0,  0, 1};
    vecs[2] = '{24'h000200, 24'd1, 1, 10, 24'h000200, 24'h000204, 12, 14, 0, 17};
    vecs[3] = '{24'h000A00, 24'd2, 0, 0,  24'h000A04, 24'h000A08, 2,  4,  4, 10};
    vecs[4] = '{24'hFFFFFC, 24'd2, 0, 0,  24'h000000, 24'h000004, 2,  4,  4, 10};

    cyc = 0; avail_cyc = 1000000; ack_dly = 0; ack_cnt = 0; hold = 1'b0; wbase = '0;
    n_rd = 0; n_wr = 0; n_fin = 0; first_rd = -1; fin_cyc = -1;
    reset = 1'b1; iniciar = 1'b0;
    direccion_mem_destino_img = '0; escrituras_totales_mem = '0;
    buf_data_available = 1'b0; buf_data = '0; escritura_mem_completada = 1'b0;

    repeat (2) step();
    chk("rst_read_buf", {31'h0, read_buf}, 32'd0);
    chk("rst_write_mem", {31'h0, write_mem}, 32'd0);
    chk("rst_fin", {31'h0, proceso_terminado}, 32'd0);
    chk("rst_addr", {8'h0, address_mem}, 32'd0);
    chk("rst_data", write_data_mem, 32'd0);
    reset = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      run_case(vecs[i], 32'hC0DE_0000 + 32'(i * 256));
      repeat (4) step();
      chk("fin_once", 32'(n_fin), 32'd1);
      chk("wr_total", 32'(n_wr), 32'(vecs[i].total));
    end

    // Async reset while a write is outstanding, with a stray iniciar before it.
    begin
      int s;
      start(24'h000300, 24'd3, 1000, 0, 32'hBEEF_0000, s);
      for (int k = 0; k < 20 && n_wr == 0; k++) step();
      chk("seq_wr_seen", 32'(n_wr), 32'd1);
      step(); step();
      direccion_mem_destino_img = 24'h000500;
      escrituras_totales_mem    = 24'd1;
      iniciar = 1'b1;
      step();
      iniciar = 1'b0;
      step();
      chk("stray_addr", {8'h0, address_mem}, 32'h000300);
      chk("stray_data", write_data_mem, 32'hBEEF_0000);
      chk("stray_wr", 32'(n_wr), 32'd1);
      chk("stray_rd", 32'(n_rd), 32'd1);
      #2 reset = 1'b1;
      #1;
      chk("arst_read_buf", {31'h0, read_buf}, 32'd0);
      chk("arst_write_mem", {31'h0, write_mem}, 32'd0);
      chk("arst_fin", {31'h0, proceso_terminado}, 32'd0);
      chk("arst_addr", {8'h0, address_mem}, 32'd0);
      chk("arst_data", write_data_mem, 32'd0);
      step(); step();
      reset = 1'b0;
      ack_cnt = 0;
      step();
    end

    vh = '{24'h000400, 24'd1, 0, 0, 24'h000400, 24'h000404, 2, 4, 0, 6};
    run_case(vh, 32'h5A5A_0000);

    // iniciar coinciding with proceso_terminado must not restart the job.
    begin
      int rd0;
      rd0 = n_rd;
      chk("fin_now", {31'h0, proceso_terminado}, 32'd1);
      iniciar = 1'b1;
      step();
      iniciar = 1'b0;
      repeat (8) step();
      chk("coinc_rd", 32'(n_rd - rd0), 32'd0);
      chk("coinc_fin", 32'(n_fin), 32'd1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
